// File: rtl/hll_param_regfile.sv
// hll_param_regfile: AXI4-Lite register file that assembles multi-word
// parameters per channel and hands each finished parameter out on a
// per-channel valid/ready stream. A read port returns status inputs and a
// pending/valid bitmap.
// Optional feature: define HLL_REGFILE_WSTRB_EN to honour wstrb on parameter
// word writes; otherwise the full 32-bit word is always written.
// Debug: dbg_w_state / dbg_r_state expose the write and read FSM states.
`timescale 1ns/1ps

module hll_param_regfile #(
  parameter int NUM_CH     = 2,
  parameter int CH_WORDS   = 3,
  parameter int NUM_STAT   = 2,
  parameter int ADDR_SHIFT = 5
) (
  input  logic                         user_clk,
  input  logic                         user_aresetn,
  // AXI4-Lite write address / data / response
  input  logic [31:0]                  s_axil_awaddr,
  input  logic                         s_axil_awvalid,
  output logic                         s_axil_awready,
  input  logic [31:0]                  s_axil_wdata,
  input  logic [3:0]                   s_axil_wstrb,
  input  logic                         s_axil_wvalid,
  output logic                         s_axil_wready,
  output logic [1:0]                   s_axil_bresp,
  output logic                         s_axil_bvalid,
  input  logic                         s_axil_bready,
  // AXI4-Lite read address / data
  input  logic [31:0]                  s_axil_araddr,
  input  logic                         s_axil_arvalid,
  output logic                         s_axil_arready,
  output logic [31:0]                  s_axil_rdata,
  output logic [1:0]                   s_axil_rresp,
  output logic                         s_axil_rvalid,
  input  logic                         s_axil_rready,
  // Parameter streams
  output logic [NUM_CH-1:0]            m_axis_param_valid,
  input  logic [NUM_CH-1:0]            m_axis_param_ready,
  output logic [NUM_CH*CH_WORDS*32-1:0] m_axis_param_data,
  // Status inputs
  input  logic [NUM_STAT*32-1:0]       stat_in,
  // Debug state visibility
  output logic [1:0]                   dbg_w_state,
  output logic                         dbg_r_state
);

  // Handshake rule for every channel here: a transfer happens on the rising
  // clock edge where valid and ready are both 1; once valid is raised the
  // source holds valid and its payload stable until that edge; ready never
  // depends combinationally on valid.

  localparam int CHW = (NUM_CH   > 1) ? $clog2(NUM_CH)   : 1;
  localparam int WCW = (CH_WORDS > 1) ? $clog2(CH_WORDS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_PARAM, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic              init_done;
  logic [31:0]       idx_q;
  logic [1:0]        bresp_q;
  logic [31:0]       rdata_q;
  logic [1:0]        rresp_q;
  logic [WCW-1:0]    wcnt [NUM_CH];
  logic [31:0]       param_mem [NUM_CH][CH_WORDS];

  logic [CHW-1:0]    ch_sel;
  logic              idx_is_ch;
  logic              wcnt_last;
  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic [31:0]       ridx;
  logic [31:0]       rd_data_c;
  logic [1:0]        rd_resp_c;
  logic [7:0]        valid_map;
  logic [7:0]        pend_map;

`ifdef HLL_REGFILE_WSTRB_EN
`else
  logic unused_wstrb;
  assign unused_wstrb = ^s_axil_wstrb;
`endif

  assign ch_sel    = idx_q[CHW-1:0];
  assign idx_is_ch = (idx_q < 32'(NUM_CH));
  assign wcnt_last = (wcnt[ch_sel] == WCW'(CH_WORDS - 1));
  assign aw_hs     = s_axil_awvalid && s_axil_awready;
  assign w_hs      = (w_state == W_DATA) && s_axil_wvalid;
  assign ar_hs     = s_axil_arvalid && s_axil_arready;

  assign s_axil_bresp = bresp_q;
  assign s_axil_rdata = rdata_q;
  assign s_axil_rresp = rresp_q;
  assign dbg_w_state  = w_state;
  assign dbg_r_state  = r_state;

  // Keep both address readies low until the first clock after reset release.
  always_ff @(posedge user_clk or negedge user_aresetn) begin
    if (!user_aresetn) init_done <= 1'b0;
    else               init_done <= 1'b1;
  end

  // Write and read FSM state registers.
  always_ff @(posedge user_clk or negedge user_aresetn) begin
    if (!user_aresetn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // Write FSM next state and handshake outputs; the finished channel's valid
  // is held in W_PARAM and the B response waits until it has been taken.
  always_comb begin
    w_next             = w_state;
    s_axil_awready     = 1'b0;
    s_axil_wready      = 1'b0;
    s_axil_bvalid      = 1'b0;
    m_axis_param_valid = '0;
    case (w_state)
      W_IDLE: begin
        s_axil_awready = init_done;
        if (s_axil_awvalid && init_done) w_next = W_DATA;
      end
      W_DATA: begin
        s_axil_wready = 1'b1;
        if (s_axil_wvalid) w_next = (idx_is_ch && wcnt_last) ? W_PARAM : W_RESP;
      end
      W_PARAM: begin
        m_axis_param_valid[ch_sel] = 1'b1;
        if (m_axis_param_ready[ch_sel]) w_next = W_RESP;
      end
      W_RESP: begin
        s_axil_bvalid = 1'b1;
        if (s_axil_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Write datapath: latch the register index, store parameter words, advance
  // or clear the per-channel word counters and record the B response.
  always_ff @(posedge user_clk or negedge user_aresetn) begin
    if (!user_aresetn) begin
      idx_q   <= '0;
      bresp_q <= RESP_OKAY;
      for (int c = 0; c < NUM_CH; c++) begin
        wcnt[c] <= '0;
        for (int w = 0; w < CH_WORDS; w++) param_mem[c][w] <= '0;
      end
    end else begin
      if (aw_hs) idx_q <= s_axil_awaddr >> ADDR_SHIFT;
      if (w_hs) begin
        if (idx_is_ch) begin
          bresp_q <= RESP_OKAY;
          for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel == CHW'(c)) begin
              for (int w = 0; w < CH_WORDS; w++) begin
                if (wcnt[c] == WCW'(w)) begin
`ifdef HLL_REGFILE_WSTRB_EN
                  for (int b = 0; b < 4; b++)
                    if (s_axil_wstrb[b]) param_mem[c][w][8*b +: 8] <= s_axil_wdata[8*b +: 8];
`else
                  param_mem[c][w] <= s_axil_wdata;
`endif
                end
              end
              wcnt[c] <= wcnt_last ? '0 : wcnt[c] + WCW'(1);
            end
          end
        end else if (idx_q == 32'h0000_000F) begin
          bresp_q <= RESP_OKAY;
          for (int c = 0; c < NUM_CH; c++) wcnt[c] <= '0;
        end else begin
          bresp_q <= RESP_SLVERR;
        end
      end
    end
  end

  // Flatten stored words: channel c at c*CH_WORDS*32, word 0 lowest.
  always_comb begin
    m_axis_param_data = '0;
    for (int c = 0; c < NUM_CH; c++)
      for (int w = 0; w < CH_WORDS; w++)
        m_axis_param_data[(c*CH_WORDS + w)*32 +: 32] = param_mem[c][w];
  end

  // Status bitmaps: channels with a partly written parameter, and live valids.
  always_comb begin
    valid_map = '0;
    pend_map  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      valid_map[c] = m_axis_param_valid[c];
      pend_map[c]  = (wcnt[c] != '0);
    end
  end

  // Read decode: bitmap register, status words, or an error pattern.
  always_comb begin
    ridx      = s_axil_araddr >> ADDR_SHIFT;
    rd_data_c = 32'hDEAD_BEEF;
    rd_resp_c = RESP_SLVERR;
    if (ridx == 32'h0000_0008) begin
      rd_data_c = {16'h0000, pend_map, valid_map};
      rd_resp_c = RESP_OKAY;
    end
    for (int s = 0; s < NUM_STAT; s++) begin
      if (ridx == 32'(16 + s)) begin
        rd_data_c = stat_in[s*32 +: 32];
        rd_resp_c = RESP_OKAY;
      end
    end
  end

  // Read FSM next state and handshake outputs.
  always_comb begin
    r_next         = r_state;
    s_axil_arready = 1'b0;
    s_axil_rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axil_arready = init_done;
        if (s_axil_arvalid && init_done) r_next = R_RESP;
      end
      R_RESP: begin
        s_axil_rvalid = 1'b1;
        if (s_axil_rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Capture read data and response at the AR handshake.
  always_ff @(posedge user_clk or negedge user_aresetn) begin
    if (!user_aresetn) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_data_c;
      rresp_q <= rd_resp_c;
    end
  end

endmodule

// File: tb/tb_hll_param_regfile.sv
// tb_hll_param_regfile: directed and randomized AXI4-Lite traffic against a
// transaction-level model of the parameter register file.
`timescale 1ns/1ps

module tb_hll_param_regfile;

  localparam int NUM_CH   = 2;
  localparam int CH_WORDS = 3;
  localparam int NUM_STAT = 2;
  localparam int DW       = NUM_CH*CH_WORDS*32;
  localparam int BUDGET   = 100;
`ifdef HLL_REGFILE_WSTRB_EN
  localparam logic [31:0] STRB_WORD_EXP = 32'h0000_CCDD;
`else
  localparam logic [31:0] STRB_WORD_EXP = 32'hAABB_CCDD;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]          awaddr = '0;
  logic                 awvalid = 1'b0;
  logic                 awready;
  logic [31:0]          wdata = '0;
  logic [3:0]           wstrb = '0;
  logic                 wvalid = 1'b0;
  logic                 wready;
  logic [1:0]           bresp;
  logic                 bvalid;
  logic                 bready = 1'b0;
  logic [31:0]          araddr = '0;
  logic                 arvalid = 1'b0;
  logic                 arready;
  logic [31:0]          rdata;
  logic [1:0]           rresp;
  logic                 rvalid;
  logic                 rready = 1'b0;
  logic [NUM_CH-1:0]    pvalid;
  logic [NUM_CH-1:0]    pready = '0;
  logic [DW-1:0]        pdata;
  logic [NUM_STAT*32-1:0] stat_in = '0;
  logic [1:0]           dbg_w_state;
  logic                 dbg_r_state;

  hll_param_regfile #(
    .NUM_CH(NUM_CH), .CH_WORDS(CH_WORDS), .NUM_STAT(NUM_STAT), .ADDR_SHIFT(5)
  ) dut (
    .user_clk(clk), .user_aresetn(rst_n),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .m_axis_param_valid(pvalid), .m_axis_param_ready(pready), .m_axis_param_data(pdata),
    .stat_in(stat_in), .dbg_w_state(dbg_w_state), .dbg_r_state(dbg_r_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: no handshake within %0d cycles at %0t", name, BUDGET, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]       m_mem [NUM_CH][CH_WORDS];
  int                m_wcnt [NUM_CH];
  logic [NUM_CH-1:0] exp_valid = '0;
  logic              exp_bvalid = 1'b0;
  logic              m_aw_busy = 1'b0;
  logic              m_wphase = 1'b0;
  logic              m_ar_busy = 1'b0;
  logic              tb_inited = 1'b0;

  // Address readies come up one clock after reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_inited = 1'b0;
    else        tb_inited = 1'b1;
  end

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_wcnt[c] = 0;
      for (int w = 0; w < CH_WORDS; w++) m_mem[c][w] = '0;
    end
    exp_valid  = '0;
    exp_bvalid = 1'b0;
    m_aw_busy  = 1'b0;
    m_wphase   = 1'b0;
    m_ar_busy  = 1'b0;
  endtask

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] strb,
                             output bit last, output logic [1:0] resp);
    last = 1'b0;
    if (idx < NUM_CH) begin
      int w;
      w = m_wcnt[idx];
      for (int b = 0; b < 4; b++) begin
`ifdef HLL_REGFILE_WSTRB_EN
        if (strb[b]) m_mem[idx][w][8*b +: 8] = d[8*b +: 8];
`else
        m_mem[idx][w][8*b +: 8] = d[8*b +: 8];
`endif
      end
      if (w == CH_WORDS-1) begin
        m_wcnt[idx] = 0;
        last = 1'b1;
      end else begin
        m_wcnt[idx] = w + 1;
      end
      resp = 2'b00;
    end else if (idx == 15) begin
      for (int c = 0; c < NUM_CH; c++) m_wcnt[c] = 0;
      resp = 2'b00;
    end else begin
      resp = 2'b10;
    end
  endtask

  task automatic model_read(input int idx, output logic [31:0] d, output logic [1:0] resp);
    logic [7:0] pend, vmap;
    pend = '0;
    vmap = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pend[c] = (m_wcnt[c] != 0);
      vmap[c] = exp_valid[c];
    end
    if (idx == 8) begin
      d = {16'h0000, pend, vmap};
      resp = 2'b00;
    end else if (idx >= 16 && idx < 16 + NUM_STAT) begin
      d = stat_in[(idx-16)*32 +: 32];
      resp = 2'b00;
    end else begin
      d = 32'hDEAD_BEEF;
      resp = 2'b10;
    end
  endtask

  function automatic logic [255:0] model_flat();
    logic [255:0] r;
    r = '0;
    for (int c = 0; c < NUM_CH; c++)
      for (int w = 0; w < CH_WORDS; w++)
        r[(c*CH_WORDS + w)*32 +: 32] = m_mem[c][w];
    return r;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("param_data",  256'(pdata),  model_flat());
    chk("param_valid", 256'(pvalid), 256'(exp_valid));
    chk("awready",     256'(awready), 256'(tb_inited && !m_aw_busy));
    chk("wready",      256'(wready),  256'(m_wphase));
    chk("bvalid",      256'(bvalid),  256'(exp_bvalid));
    chk("arready",     256'(arready), 256'(tb_inited && !m_ar_busy));
    chk("rvalid",      256'(rvalid),  256'(m_ar_busy));
  end

  // ---------------- driver tasks ----------------
  task automatic do_write(input int idx, input logic [31:0] d, input logic [3:0] strb,
                          input int hold, output logic [1:0] gresp);
    bit last;
    logic [1:0] eresp;
    int n;
    @(negedge clk);
    awaddr  = (32'(idx) << 5) | 32'($urandom_range(0, 31));
    awvalid = 1'b1;
    n = 0;
    while (!awready && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) timeout("aw_handshake");
    @(posedge clk);
    m_aw_busy = 1'b1;
    m_wphase  = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    wdata   = d;
    wstrb   = strb;
    wvalid  = 1'b1;
    n = 0;
    while (!wready && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) timeout("w_handshake");
    @(posedge clk);
    m_wphase = 1'b0;
    model_write(idx, d, strb, last, eresp);
    if (last) exp_valid[idx] = 1'b1;
    else      exp_bvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    if (last) begin
      repeat (hold) @(negedge clk);
      pready[idx] = 1'b1;
      @(posedge clk);
      exp_valid[idx] = 1'b0;
      exp_bvalid = 1'b1;
      @(negedge clk);
      pready[idx] = 1'b0;
    end
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) timeout("b_handshake");
    gresp = bresp;
    chk("bresp", 256'(bresp), 256'(eresp));
    @(posedge clk);
    exp_bvalid = 1'b0;
    m_aw_busy  = 1'b0;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic do_read(input int idx, output logic [31:0] got, output logic [1:0] gresp);
    logic [31:0] ed;
    logic [1:0] er;
    int n;
    @(negedge clk);
    araddr  = (32'(idx) << 5) | 32'($urandom_range(0, 31));
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) timeout("ar_handshake");
    @(posedge clk);
    m_ar_busy = 1'b1;
    model_read(idx, ed, er);
    @(negedge clk);
    arvalid = 1'b0;
    rready  = 1'b1;
    n = 0;
    while (!rvalid && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) timeout("r_handshake");
    got   = rdata;
    gresp = rresp;
    chk("rdata", 256'(rdata), 256'(ed));
    chk("rresp", 256'(rresp), 256'(er));
    @(posedge clk);
    m_ar_busy = 1'b0;
    @(negedge clk);
    rready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] got, got2;
    logic [1:0]  gr, gr2;
    bit last;
    logic [1:0] er;

    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_awready", 256'(awready), 256'(0));
    chk("rst_arready", 256'(arready), 256'(0));
    chk("rst_valid",   256'(pvalid),  256'(0));
    chk("rst_data",    256'(pdata),   256'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_awready", 256'(awready), 256'(1));
    chk("rel_arready", 256'(arready), 256'(1));

    // Channel 0 three-word parameter, taken immediately.
    do_write(0, 32'h11, 4'hF, 0, gr);
    do_write(0, 32'h22, 4'hF, 0, gr);
    do_write(0, 32'h33, 4'hF, 0, gr);
    chk("ch0_param", 256'(pdata[95:0]), 256'(96'h00000033_00000022_00000011));
    chk("ch0_bresp", 256'(gr), 256'(2'b00));

    // Channel 1 last word held off by the consumer for 10 cycles.
    do_write(1, 32'hA1, 4'hF, 0, gr);
    do_write(1, 32'hA2, 4'hF, 0, gr);
    do_write(1, 32'hA3, 4'hF, 10, gr);
    chk("ch1_bresp", 256'(gr), 256'(2'b00));

    // Independent word counters seen through the bitmap register.
    do_write(15, 32'h0, 4'hF, 0, gr);
    do_write(0, 32'h1000, 4'hF, 0, gr);
    do_write(1, 32'h2000, 4'hF, 0, gr);
    do_write(0, 32'h1001, 4'hF, 0, gr);
    do_read(8, got, gr);
    chk("bitmap_0300", 256'(got), 256'(32'h0000_0300));

    // Error paths and status reads.
    do_write(48, 32'h1234_5678, 4'hF, 0, gr);
    chk("bad_write_resp", 256'(gr), 256'(2'b10));
    do_read(5, got, gr);
    chk("bad_read_data", 256'(got), 256'(32'hDEAD_BEEF));
    chk("bad_read_resp", 256'(gr), 256'(2'b10));
    stat_in = {32'h0000_CAFE, 32'h1234_0001};
    do_read(17, got, gr);
    chk("stat1_data", 256'(got), 256'(32'h0000_CAFE));
    chk("stat1_resp", 256'(gr), 256'(2'b00));

    // Simultaneous AW and AR.
    fork
      do_write(0, 32'h5555_AAAA, 4'hF, 0, gr);
      do_read(16, got2, gr2);
    join
    chk("sim_read", 256'(got2), 256'(32'h1234_0001));

    // Bitmap read while channel 1 is presenting its parameter.
    do_write(15, 32'h0, 4'hF, 0, gr);
    do_write(1, 32'hB1, 4'hF, 0, gr);
    do_write(1, 32'hB2, 4'hF, 0, gr);
    fork
      do_write(1, 32'hB3, 4'hF, 8, gr);
      begin
        repeat (4) @(negedge clk);
        do_read(8, got, gr2);
        chk("bitmap_valid1", 256'(got), 256'(32'h0000_0002));
      end
    join

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      int op, idx;
      op = $urandom_range(0, 9);
      stat_in = {$urandom, $urandom};
      if (op < 6) begin
        case ($urandom_range(0, 5))
          0, 1: idx = 0;
          2, 3: idx = 1;
          4:    idx = 15;
          default: begin
            idx = $urandom_range(2, 255);
            if (idx == 15) idx = 16;
          end
        endcase
        do_write(idx, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 4), gr);
      end else begin
        case ($urandom_range(0, 4))
          0: idx = 8;
          1: idx = 16;
          2: idx = 17;
          3: idx = 18;
          default: idx = $urandom_range(0, 255);
        endcase
        do_read(idx, got, gr);
      end
    end

    // Reset while a parameter is being presented.
    do_write(15, 32'h0, 4'hF, 0, gr);
    do_write(1, 32'hC1, 4'hF, 0, gr);
    do_write(1, 32'hC2, 4'hF, 0, gr);
    @(negedge clk);
    awaddr  = 32'h20;
    awvalid = 1'b1;
    @(posedge clk);
    m_aw_busy = 1'b1;
    m_wphase  = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    wdata   = 32'hC3;
    wstrb   = 4'hF;
    wvalid  = 1'b1;
    @(posedge clk);
    m_wphase = 1'b0;
    model_write(1, 32'hC3, 4'hF, last, er);
    if (last) exp_valid[1] = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    chk("pre_rst_valid", 256'(pvalid), 256'(2'b10));
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_valid",   256'(pvalid),  256'(0));
    chk("rst_mid_awready", 256'(awready), 256'(0));
    chk("rst_mid_bvalid",  256'(bvalid),  256'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel2_awready_low", 256'(awready), 256'(0));
    @(posedge clk); #1;
    chk("rel2_awready", 256'(awready), 256'(1));
    chk("rel2_data",    256'(pdata),   256'(0));

    // Byte-lane behaviour on a cleared word.
    do_write(0, 32'hAABB_CCDD, 4'h3, 0, gr);
    chk("wstrb_word", 256'(pdata[31:0]), 256'(STRB_WORD_EXP));

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #500000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hll_param_regfile.md
HLL_PARAM_REGFILE -- requirements
Module: hll_param_regfile

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of parameter output channels (1..8).
REQ-002 SHALL have parameter CH_WORDS, default 3: 32-bit words per channel parameter (1..8).
REQ-003 SHALL have parameter NUM_STAT, default 2: number of readable 32-bit status inputs (1..8).
REQ-004 SHALL have parameter ADDR_SHIFT, default 5: register index = address >> ADDR_SHIFT.
REQ-005 SHALL have port user_clk, input, 1: single clock for all logic; one clock, reset asynchronous active-low.
REQ-006 SHALL have port user_aresetn, input, 1: asynchronous active-low reset.
REQ-007 SHALL have ports s_axil_aw*/w*/b*/ar*/r* (addr 32, data 32, wstrb 4, resp 2): AXI4-Lite slave, no prot.
REQ-008 SHALL have port m_axis_param_valid, output, NUM_CH: per-channel parameter valid.
REQ-009 SHALL have port m_axis_param_ready, input, NUM_CH: per-channel parameter ready.
REQ-010 SHALL have port m_axis_param_data, output, NUM_CH*CH_WORDS*32: channel c occupies slice c*CH_WORDS*32 upward, word 0 lowest.
REQ-011 SHALL have port stat_in, input, NUM_STAT*32: status words, sampled on read.

Function
REQ-012 Write FSM states SHALL be W_IDLE, W_DATA, W_PARAM, W_RESP.
REQ-013 W_IDLE: awready=1; on AW handshake SHALL latch index, go W_DATA, assert wready next cycle.
REQ-014 W_DATA: on W handshake SHALL drop wready and decode index.
REQ-015 Index c < NUM_CH SHALL store wdata into word wcnt[c] of channel c; wcnt[c] is a per-channel counter.
REQ-016 If wcnt[c] < CH_WORDS-1: wcnt[c] increments, go W_RESP with bresp OKAY.
REQ-017 If wcnt[c] = CH_WORDS-1: wcnt[c] wraps to 0, valid[c] asserts next cycle, go W_PARAM, B withheld.
REQ-018 W_PARAM: valid[c] held, data stable; on valid&ready SHALL deassert valid, go W_RESP (bresp OKAY).
REQ-019 Index 0x0F SHALL clear all wcnt to 0, bresp OKAY; other channels' stored data unchanged.
REQ-020 Any other write index SHALL cause no state change and bresp SLVERR.
REQ-021 W_RESP: bvalid=1 until bready, then W_IDLE; one transaction outstanding at a time.
REQ-022 Read FSM states SHALL be R_IDLE (arready=1) and R_RESP.
REQ-023 On AR handshake SHALL register rdata/rresp, assert rvalid next cycle, hold until rready, then R_IDLE.
REQ-024 Read index 0x10+s (s < NUM_STAT) SHALL return stat_in word s, OKAY.
REQ-025 Read index 0x08 SHALL return {pending wcnt-nonzero bitmap in [15:8], valid bitmap in [7:0]}, OKAY.
REQ-026 Other read indices SHALL return 0xDEADBEEF with SLVERR.
REQ-027 Read and write FSMs SHALL operate independently; simultaneous AR and AW both accepted same cycle.

Reset
REQ-028 On user_aresetn low, all ready/valid outputs SHALL be 0 immediately; FSMs to IDLE; wcnt, param data, rdata, bresp, rresp to 0.
REQ-029 Reset mid-W_PARAM SHALL drop valid without completing the handshake or issuing B.
REQ-030 First cycle after reset release, awready and arready SHALL rise to 1.

Configuration
REQ-031 Macro HLL_REGFILE_WSTRB_EN defined: param word writes SHALL update only byte lanes with wstrb=1; wcnt advances regardless.
REQ-032 Macro HLL_REGFILE_WSTRB_EN undefined: wstrb ignored, full 32-bit word written.

Verification
REQ-033 Ch0 writes 0x11,0x22,0x33 (CH_WORDS=3), ready=1 -> valid[0] one cycle, data[95:0]=0x33_00000022_00000011 equivalent, third B after handshake.
REQ-034 Ch1 last word with ready=0 for 10 cycles -> valid[1] held, no bvalid; ready=1 -> B OKAY within 2 cycles.
REQ-035 Ch0 word0, ch1 word0, ch0 word1 -> wcnt independent; read 0x08 returns 0x0300.
REQ-036 Write index 0x30 -> SLVERR, no output change; read index 0x05 -> 0xDEADBEEF SLVERR; read 0x11 with stat_in[63:32]=0xCAFE -> 0xCAFE OKAY.
REQ-037 Assert reset during W_PARAM -> valid 0 same cycle, awready 1 cycle after release.
REQ-038 With HLL_REGFILE_WSTRB_EN, wdata 0xAABBCCDD wstrb 0x3 over prior 0 -> word 0x0000CCDD; without macro -> 0xAABBCCDD.
